ps2_keyboard_matrix: RTL
========================

# ps2_keyboard_matrix

Converts a PS/2 keyboard (scan code set 2) into the 8×5 ZX Spectrum key matrix that the ULA samples on port #FE reads. It sits on the keyboard side of the ULA's `kd[4:0]` inputs. It receives PS/2 frames, tracks make/break/extended prefixes and holds a per-key pressed state. For each CPU read, it answers with the active-low column bits for whichever rows the CPU selects on A15..A8.

## Interface
- `TIMEOUT_CYCLES`, default 2048: number of clk14 cycles with no PS/2 falling edge after which a partial frame is discarded.
- `clk14` input 1: system clock, 14 MHz.
- `rst_n` input 1: reset; asynchronous, active-low.
- `ps2_clk` input 1: PS/2 clock from the keyboard, asynchronous, open-collector (idle high).
- `ps2_dat` input 1: PS/2 data from the keyboard, asynchronous.
- `addr_hi` input 8: CPU A15..A8. A 0 in bit r selects matrix row r.
- `kd` output 5: active-low key columns to the ULA. Bit c is 0 if any selected row has key c pressed.
- `frame_err` output 1: one-cycle pulse when a frame is discarded (bad start, parity or stop bit, or timeout).

## Operation
- **Synchronisers:** `ps2_clk` and `ps2_dat` each pass through 2-FF synchronisers. A falling edge is defined as synced clk going from 1 to 0.
- **Receiver:**
  - Receives 11 bits per frame, each sampled on a falling edge: start (0), 8 data bits LSB first, odd parity, stop (1).
  - A 4-bit counter tracks position in the frame. It is cleared on frame end, on timeout and on reset.
  - The byte is accepted only if start=0, parity is odd over data+parity, and stop=1. Otherwise the byte is dropped and `frame_err` pulses.
- **Decoder state:** flags `brk` and `ext`, each cleared after any non-prefix byte.
  - Byte F0 sets `brk`.
  - Byte E0 sets `ext`.
  - Byte AA (BAT) clears every key and both flags.
  - Any other byte is a key code. It is applied as a press if `brk`=0 and a release if `brk`=1.
  - Unmapped codes change no key but still clear both flags.
- **Matrix rows** (column 0 listed first):
  - Row 0: CS, Z, X, C, V
  - Row 1: A, S, D, F, G
  - Row 2: Q, W, E, R, T
  - Row 3: 1, 2, 3, 4, 5
  - Row 4: 0, 9, 8, 7, 6
  - Row 5: P, O, I, U, Y
  - Row 6: ENTER, L, K, J, H
  - Row 7: SPACE, SS, M, N, B
- **Non-extended mapping:**
  - Letters, digits, Enter (5A) and Space (29) use their standard set-2 codes, e.g. A=1C, Z=1A, Q=15, 1=16, 0=45, P=4D.
  - Left Shift 12 and Right Shift 59 map to CS.
  - Left Ctrl 14 maps to SS.
  - Backspace 66 maps to the composite CS+0.
- **Extended mapping (ext=1):**
  - E0 6B (left) → CS+5
  - E0 72 (down) → CS+6
  - E0 75 (up) → CS+7
  - E0 74 (right) → CS+8
  - E0 14 (right Ctrl) → SS
  - All other extended codes are ignored.
- **Composite keys:** each composite key has its own state bit. A matrix position reads pressed if its direct key bit OR any composite bit covering it is set. Releasing an arrow therefore never releases a still-held Shift.
- **Column output:** `kd[c]` = NOT( OR over r of (`addr_hi[r]`==0 AND pressed[r][c]) ). With `addr_hi`=FF, `kd`=11111.

## Timing
- **Reset values:**
  - `kd`=11111 regardless of `addr_hi`.
  - All keys released, `brk`=`ext`=0, bit counter=0.
  - `frame_err`=0.
- **Synchroniser latency:** a `ps2_clk` falling edge is seen 2–3 clk14 cycles after the pin transition.
- **Decode latency:** the key state updates exactly 2 clk14 cycles after the synchronised 11th falling edge. Cycle 1 validates and registers the byte; cycle 2 decodes and applies it.
- **kd path:** `kd` is combinational from the key state and `addr_hi`, with no register. A port #FE read sees the state in the same cycle `addr_hi` changes.
- **Timeout:** the idle counter runs only while the bit counter ≠ 0. When it reaches `TIMEOUT_CYCLES`, the frame is discarded and `frame_err` pulses.
- **Simultaneous events:** a falling edge in the same cycle as timeout counts as bit 0 of a new frame.
- **Reset mid-frame:** asserting `rst_n` during a frame aborts the partial byte. It must not produce a key event or a `frame_err` pulse.
- **Repeats:** a key already pressed that receives another make (typematic repeat) stays pressed. A break for a key not pressed is a no-op.

## Test plan
- Reset with `addr_hi` swept 00..FF → `kd`=11111 for every value; `frame_err`=0.
- Send 1C:
  - `addr_hi`=FD → `kd`=11110; `addr_hi`=FE → `kd`=11111.
  - Then send F0 1C → `kd`=11111 at FD.
- Send 12 then 1A:
  - `addr_hi`=FE → `kd`=11100; `addr_hi`=00 → `kd`=11100.
  - Then send F0 1A → `kd`=11110 at FE.
- Send 12, then E0 75, then E0 F0 75:
  - After E0 75: `addr_hi`=EF → `kd`=10111; FE → 11110.
  - After E0 F0 75: FE still → 11110 (Shift held); EF → 11111.
- Send 1C with even parity → no key change, one `frame_err` pulse. Then send 5 bits of a frame, idle 3000 cycles → one `frame_err` pulse. Then send valid 29 → `addr_hi`=7F gives `kd`=11110.
- Hold 15 and 4D, then send AA → `addr_hi`=00 gives `kd`=11111. Assert `rst_n` during the 6th bit of a frame → no key change; next valid frame decodes correctly.

Source files
------------

// File: rtl/ps2_keyboard_matrix_if.sv
// Pins between the keyboard/CPU side and the PS/2-to-ZX matrix converter.
// slave is the converter; master is whatever drives the pins and reads kd.
interface ps2_keyboard_matrix_if;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] addr_hi;
  logic [4:0] kd;
  logic       frame_err;

  modport slave  (input ps2_clk, ps2_dat, addr_hi, output kd, frame_err);
  modport master (output ps2_clk, ps2_dat, addr_hi, input kd, frame_err);
endinterface

// File: rtl/ps2_keyboard_matrix.sv
// PS/2 set-2 receiver feeding an 8x5 ZX Spectrum key matrix; kd is read combinationally
// from the held key state for whichever rows A15..A8 select.
module ps2_keyboard_matrix #(
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                  clk14,
  input  logic                  rst_n,
  ps2_keyboard_matrix_if.slave  bus
);
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

  logic [2:0]        clk_s_q, clk_s_d;
  logic [1:0]        dat_s_q, dat_s_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [10:0]       sh_q, sh_d;
  logic [IW-1:0]     idle_q, idle_d;
  logic              byte_vld_q, byte_vld_d;
  logic [7:0]        byte_q, byte_d;
  logic              frame_err_q, frame_err_d;
  logic              brk_q, brk_d, ext_q, ext_d;
  logic [7:0][4:0]   key_q, key_d;
  logic [5:0]        comp_q, comp_d;   // Bksp, Left, Down, Up, Right, RCtrl
  logic [7:0][4:0]   pressed;
  logic [4:0]        col_act;
  logic              fall, timeout;
  logic [10:0]       frame;
  logic [6:0]        m;

  // {valid, row, col} for non-extended single-position keys
  function automatic logic [6:0] map_code(input logic [7:0] c);
    case (c)
      8'h12, 8'h59: return {1'b1, 3'd0, 3'd0};
      8'h1A: return {1'b1, 3'd0, 3'd1};
      8'h22: return {1'b1, 3'd0, 3'd2};
      8'h21: return {1'b1, 3'd0, 3'd3};
      8'h2A: return {1'b1, 3'd0, 3'd4};
      8'h1C: return {1'b1, 3'd1, 3'd0};
      8'h1B: return {1'b1, 3'd1, 3'd1};
      8'h23: return {1'b1, 3'd1, 3'd2};
      8'h2B: return {1'b1, 3'd1, 3'd3};
      8'h34: return {1'b1, 3'd1, 3'd4};
      8'h15: return {1'b1, 3'd2, 3'd0};
      8'h1D: return {1'b1, 3'd2, 3'd1};
      8'h24: return {1'b1, 3'd2, 3'd2};
      8'h2D: return {1'b1, 3'd2, 3'd3};
      8'h2C: return {1'b1, 3'd2, 3'd4};
      8'h16: return {1'b1, 3'd3, 3'd0};
      8'h1E: return {1'b1, 3'd3, 3'd1};
      8'h26: return {1'b1, 3'd3, 3'd2};
      8'h25: return {1'b1, 3'd3, 3'd3};
      8'h2E: return {1'b1, 3'd3, 3'd4};
      8'h45: return {1'b1, 3'd4, 3'd0};
      8'h46: return {1'b1, 3'd4, 3'd1};
      8'h3E: return {1'b1, 3'd4, 3'd2};
      8'h3D: return {1'b1, 3'd4, 3'd3};
      8'h36: return {1'b1, 3'd4, 3'd4};
      8'h4D: return {1'b1, 3'd5, 3'd0};
      8'h44: return {1'b1, 3'd5, 3'd1};
      8'h43: return {1'b1, 3'd5, 3'd2};
      8'h3C: return {1'b1, 3'd5, 3'd3};
      8'h35: return {1'b1, 3'd5, 3'd4};
      8'h5A: return {1'b1, 3'd6, 3'd0};
      8'h4B: return {1'b1, 3'd6, 3'd1};
      8'h42: return {1'b1, 3'd6, 3'd2};
      8'h3B: return {1'b1, 3'd6, 3'd3};
      8'h33: return {1'b1, 3'd6, 3'd4};
      8'h29: return {1'b1, 3'd7, 3'd0};
      8'h14: return {1'b1, 3'd7, 3'd1};
      8'h3A: return {1'b1, 3'd7, 3'd2};
      8'h31: return {1'b1, 3'd7, 3'd3};
      8'h32: return {1'b1, 3'd7, 3'd4};
      default: return 7'd0;
    endcase
  endfunction

  // Receiver: frame bits land LSB-first, so after 11 shifts sh[0] is start and sh[10] stop
  always_comb begin
    clk_s_d     = {clk_s_q[1:0], bus.ps2_clk};
    dat_s_d     = {dat_s_q[0], bus.ps2_dat};
    fall        = clk_s_q[2] & ~clk_s_q[1];
    timeout     = (bit_cnt_q != 4'd0) && (idle_q == IW'(TIMEOUT_CYCLES - 1));
    frame       = {dat_s_q[1], sh_q[10:1]};
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    idle_d      = (bit_cnt_q != 4'd0) ? idle_q + 1'b1 : '0;
    byte_vld_d  = 1'b0;
    byte_d      = byte_q;
    frame_err_d = 1'b0;
    if (timeout) begin
      frame_err_d = 1'b1;
      bit_cnt_d   = 4'd0;
      idle_d      = '0;
    end
    if (fall) begin
      idle_d = '0;
      if (!timeout && bit_cnt_q == 4'd10) begin
        bit_cnt_d = 4'd0;
        if (!frame[0] && (^frame[9:1]) && frame[10]) begin
          byte_vld_d = 1'b1;
          byte_d     = frame[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        sh_d      = frame;
        bit_cnt_d = timeout ? 4'd1 : bit_cnt_q + 4'd1;
      end
    end
  end

  // Decoder: prefixes latch, any other byte consumes and clears them
  always_comb begin
    brk_d  = brk_q;
    ext_d  = ext_q;
    key_d  = key_q;
    comp_d = comp_q;
    m      = map_code(byte_q);
    if (byte_vld_q) begin
      if (byte_q == 8'hF0) brk_d = 1'b1;
      else if (byte_q == 8'hE0) ext_d = 1'b1;
      else if (byte_q == 8'hAA) begin
        key_d  = '0;
        comp_d = '0;
        brk_d  = 1'b0;
        ext_d  = 1'b0;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (ext_q) begin
          case (byte_q)
            8'h6B:   comp_d[1] = ~brk_q;
            8'h72:   comp_d[2] = ~brk_q;
            8'h75:   comp_d[3] = ~brk_q;
            8'h74:   comp_d[4] = ~brk_q;
            8'h14:   comp_d[5] = ~brk_q;
            default: ;
          endcase
        end else if (byte_q == 8'h66) comp_d[0] = ~brk_q;
        else if (m[6]) key_d[m[5:3]][m[2:0]] = ~brk_q;
      end
    end
  end

  always_comb begin
    pressed        = key_q;
    pressed[0][0]  = key_q[0][0] | (|comp_q[4:0]);
    pressed[4][0]  = key_q[4][0] | comp_q[0];
    pressed[3][4]  = key_q[3][4] | comp_q[1];
    pressed[4][4]  = key_q[4][4] | comp_q[2];
    pressed[4][3]  = key_q[4][3] | comp_q[3];
    pressed[4][2]  = key_q[4][2] | comp_q[4];
    pressed[7][1]  = key_q[7][1] | comp_q[5];
    col_act = '0;
    for (int r = 0; r < 8; r++)
      if (!bus.addr_hi[r]) col_act = col_act | pressed[r];
    bus.kd = ~col_act;
  end

  assign bus.frame_err = frame_err_q;

  always_ff @(posedge clk14 or negedge rst_n) begin
    if (!rst_n) begin
      clk_s_q     <= 3'b111;
      dat_s_q     <= 2'b11;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      idle_q      <= '0;
      byte_vld_q  <= 1'b0;
      byte_q      <= '0;
      frame_err_q <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      key_q       <= '0;
      comp_q      <= '0;
    end else begin
      clk_s_q     <= clk_s_d;
      dat_s_q     <= dat_s_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      idle_q      <= idle_d;
      byte_vld_q  <= byte_vld_d;
      byte_q      <= byte_d;
      frame_err_q <= frame_err_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      key_q       <= key_d;
      comp_q      <= comp_d;
    end
  end
endmodule
